req_ack_arb: RTL and testbench
==============================

# req_ack_arb

Parametrised N-channel request/acknowledge responder: successor to the single-channel req/ack DUT. Arbitrates round-robin among level requests and returns a one-cycle ack pulse to the granted channel a programmable number of cycles after grant. Detects requests withdrawn before ack and reports them as errors. Sits between multiple requesters and a shared resource; driven by the same bench/binder style of environment.

## Interface
- NUM_CH, 4: number of requester channels, ≥2.
- ACK_LATENCY, 2: cycles from grant edge to ack assertion, ≥1.
- CW, $clog2(NUM_CH): channel-index width (derived, not overridden).
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NUM_CH  per-channel level request; high = request pending.
- ack  out  NUM_CH  one-hot, one-cycle acknowledge pulse.
- busy  out  1  high while a grant is outstanding (GRANT or ACK state).
- gnt_id  out  CW  index of the currently or most recently granted channel.
- err  out  1  one-cycle pulse on request abort.
- err_id  out  CW  channel that aborted; holds until the next abort.

## Operation
- States: IDLE, GRANT, ACK.
- Reset (rst_n low at an edge): state=IDLE, ack=0, busy=0, err=0, gnt_id=0, err_id=0, rr pointer=0, latency counter=0. Mid-operation reset drops any grant without ack or err.
- IDLE: if any req bit is high, pick the first set bit searching from the rr pointer upward with wrap (pointer, pointer+1, …, NUM_CH-1, 0, …). Register gnt_id, set busy, load counter=ACK_LATENCY-1, go to GRANT. If no req, stay in IDLE.
- GRANT: at each edge sample req[gnt_id].
  - low → abort: err=1, err_id=gnt_id, busy=0, pointer=gnt_id+1 (mod NUM_CH), go to IDLE; no ack.
  - high and counter==0 → ack[gnt_id]=1, go to ACK.
  - high and counter>0 → decrement counter.
- ACK: ack is high for exactly this one cycle. At the next edge: ack=0, busy=0, pointer=gnt_id+1 (mod NUM_CH), go to IDLE. No arbitration happens at this edge. req is not sampled during the ACK cycle, because the requester deasserts on the edge where it sees ack.
- A req still high in IDLE after an ack counts as a new request. Each ack consumes exactly one request.
- Requests on non-granted channels are held and never dropped. Round-robin guarantees each channel is served within NUM_CH grants.
- Pointer wrap: NUM_CH-1 + 1 → 0. When NUM_CH is not a power of 2, use an explicit compare, not natural overflow.

## Timing
- req first sampled high at edge t (IDLE) → gnt_id/busy valid after t → ack high in the cycle after edge t+ACK_LATENCY → busy low after edge t+ACK_LATENCY+1.
- Minimum request-to-request service period is ACK_LATENCY+2 cycles. The next grant happens at edge t+ACK_LATENCY+2 at the earliest.
- Abort is detected at the first GRANT-state edge that samples req[gnt_id] low. err is high for the following cycle only.
- At most one ack bit is high in any cycle; ack and err are never high in the same cycle.
- All outputs are registered; there are no combinational paths from req to any output.

## Structure
- Package req_ack_pkg: state enum typedef (IDLE/GRANT/ACK), the clog2-based width helper, and the default parameter constants.
- Sub-module rr_pick: combinational round-robin selector with inputs req and pointer and outputs valid and index. The parent instantiates it once.
- SVA binder module req_ack_arb_sva, bound like the existing binder. Properties:
  - ack is onehot0.
  - ack is a single-cycle pulse.
  - ack occurs exactly ACK_LATENCY+1 cycles after grant, unless err fires.
  - no ack and err in the same cycle.
  - busy is low in IDLE.

## Test plan
Parameters for all scenarios: NUM_CH=4, ACK_LATENCY=2.
- Single req[1] pulse held until ack → ack=4'b0010 for one cycle, 3 cycles after the first sampled edge; gnt_id=1; busy low one cycle later; err never asserts.
- req=4'b1111 held, each channel dropping its bit on its ack → acks in order ch0, ch1, ch2, ch3, spaced 4 cycles apart; no channel acked twice.
- req[2] held high continuously for 12 cycles → repeated acks to ch2 every 4 cycles, each a single-cycle pulse.
- req[3] raised, then dropped one cycle after grant → err=1 for one cycle, err_id=3, no ack; next grant goes to ch0 if pending.
- rst_n low for 1 cycle while in GRANT with req[0] high → all outputs 0 the cycle after the reset edge, no ack for the old grant; the request is re-granted to ch0 from pointer 0 after reset releases.
- Rerun with NUM_CH=3, ACK_LATENCY=1: req=3'b111 gives acks ch0→ch1→ch2→ch0, showing pointer wrap at a non-power-of-2 count, with a 3-cycle service period.

Source files
------------

// File: rtl/req_ack_pkg.sv
// req_ack_pkg
// Shared definitions for the N-channel request/acknowledge arbiter:
//   - state_t         : arbiter FSM states (IDLE, GRANT, ACK)
//   - DEF_NUM_CH      : default number of requester channels
//   - DEF_ACK_LATENCY : default cycles from grant edge to ack
//   - idx_width()     : clog2-based width helper, never narrower than 1 bit
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_ACK_LATENCY = 2;

  // Width needed to hold values 0..n-1; a 1-bit field is kept for n <= 2 so
  // that counters and indices never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_ack_arb_sva.sv
// req_ack_arb_sva
// Property checker bound onto req_ack_arb.
// Ports (all observed, none driven):
//   clk, rst_n  clock and synchronous active-low reset of the arbiter
//   ack         acknowledge vector
//   busy, err   status outputs
//   state       arbiter FSM state
module req_ack_arb_sva
  import req_ack_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ACK_LATENCY = DEF_ACK_LATENCY
) (
  input logic              clk,
  input logic              rst_n,
  input logic [NUM_CH-1:0] ack,
  input logic              busy,
  input logic              err,
  input state_t            state
);

  // Consecutive busy cycles preceding the current one. busy always drops for
  // at least one cycle between grants, so this measures time since grant.
  logic [15:0] busy_age;

  always_ff @(posedge clk) begin
    if (!rst_n)    busy_age <= '0;
    else if (!busy) busy_age <= '0;
    else           busy_age <= busy_age + 16'd1;
  end

  // An ack lands exactly after ACK_LATENCY grant cycles; a grant that survives
  // that long without an abort must produce the ack.
  always @(posedge clk) begin
    if (rst_n) begin
      if (|ack) a_ack_latency: assert (busy_age == 16'(ACK_LATENCY));
      if (busy && busy_age == 16'(ACK_LATENCY)) a_ack_due: assert (|ack);
    end
  end

  a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
  a_ack_pulse:   assert property (@(posedge clk) disable iff (!rst_n) (|ack) |=> !(|ack));
  a_ack_no_err:  assert property (@(posedge clk) disable iff (!rst_n) !((|ack) && err));
  a_idle_busy:   assert property (@(posedge clk) disable iff (!rst_n) (state == IDLE) |-> !busy);

endmodule

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin selector. Searches req starting at pointer and
// moving upward with wrap-around; reports the first set channel.
// Ports:
//   req     in  NUM_CH  pending requests
//   pointer in  CW      channel with highest priority this round (< NUM_CH)
//   valid   out 1       at least one request is pending
//   index   out CW      selected channel (equals pointer when nothing pending)
module rr_pick
  import req_ack_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CW     = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     pointer,
  output logic              valid,
  output logic [CW-1:0]     index
);

  // Channel sitting 'off' places above p, wrapped with an explicit compare so
  // non-power-of-two channel counts wrap correctly.
  function automatic logic [CW-1:0] add_wrap(input logic [CW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CW'(s);
  endfunction

  // rot[gi] is the request of the channel gi positions after the pointer.
  logic [NUM_CH-1:0] rot;
  logic [CW-1:0]     pos [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
    assign pos[gi] = add_wrap(pointer, gi);
    assign rot[gi] = req[pos[gi]];
  end

  // Scan from farthest to nearest so the closest set channel wins.
  always_comb begin
    valid = |rot;
    index = pointer;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) index = pos[i];
    end
  end

endmodule

// File: rtl/req_ack_arb.sv
// req_ack_arb
// N-channel round-robin request/acknowledge responder. A granted channel
// receives a one-cycle ack pulse ACK_LATENCY+1 cycles after its grant edge,
// provided it keeps its request high; withdrawing early raises err instead.
// Ports:
//   clk    in  1       clock, posedge
//   rst_n  in  1       synchronous active-low reset
//   req    in  NUM_CH  level requests
//   ack    out NUM_CH  one-hot single-cycle acknowledge
//   busy   out 1       grant outstanding (GRANT or ACK)
//   gnt_id out CW      current / most recent granted channel
//   err    out 1       single-cycle abort pulse
//   err_id out CW      channel of the most recent abort
module req_ack_arb
  import req_ack_pkg::*;
#(
  parameter  int NUM_CH      = DEF_NUM_CH,
  parameter  int ACK_LATENCY = DEF_ACK_LATENCY,
  localparam int CW          = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] ack,
  output logic              busy,
  output logic [CW-1:0]     gnt_id,
  output logic              err,
  output logic [CW-1:0]     err_id
);

  localparam int LW = idx_width(ACK_LATENCY);

  state_t            state_reg, state_next;
  logic [NUM_CH-1:0] ack_reg, ack_next;
  logic              busy_reg, busy_next;
  logic              err_reg, err_next;
  logic [CW-1:0]     gnt_id_reg, gnt_id_next;
  logic [CW-1:0]     err_id_reg, err_id_next;
  logic [CW-1:0]     ptr_reg, ptr_next;
  logic [LW-1:0]     cnt_reg, cnt_next;

  logic              pick_valid;
  logic [CW-1:0]     pick_idx;
  logic              req_hold;
  logic [CW-1:0]     after_gnt;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_pick (
    .req     (req),
    .pointer (ptr_reg),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  assign req_hold  = req[gnt_id_reg];
  // Next round starts just past the channel that was served (or aborted).
  assign after_gnt = (gnt_id_reg == CW'(NUM_CH - 1)) ? '0 : gnt_id_reg + CW'(1);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ack_reg    <= '0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
      gnt_id_reg <= '0;
      err_id_reg <= '0;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ack_reg    <= ack_next;
      busy_reg   <= busy_next;
      err_reg    <= err_next;
      gnt_id_reg <= gnt_id_next;
      err_id_reg <= err_id_next;
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_valid) state_next = GRANT;
      GRANT: begin
        if (!req_hold)            state_next = IDLE;
        else if (cnt_reg == '0)   state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ack_next    = '0;
    err_next    = 1'b0;
    busy_next   = busy_reg;
    gnt_id_next = gnt_id_reg;
    err_id_next = err_id_reg;
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        busy_next = pick_valid;
        if (pick_valid) begin
          gnt_id_next = pick_idx;
          cnt_next    = LW'(ACK_LATENCY - 1);
        end
      end
      GRANT: begin
        if (!req_hold) begin
          err_next    = 1'b1;
          err_id_next = gnt_id_reg;
          busy_next   = 1'b0;
          ptr_next    = after_gnt;
        end else if (cnt_reg == '0) begin
          ack_next = NUM_CH'(1) << gnt_id_reg;
        end else begin
          cnt_next = cnt_reg - LW'(1);
        end
      end
      ACK: begin
        // The requester drops req on the edge it sees ack, so req is ignored here.
        busy_next = 1'b0;
        ptr_next  = after_gnt;
      end
      default: busy_next = 1'b0;
    endcase
  end

  assign ack    = ack_reg;
  assign busy   = busy_reg;
  assign err    = err_reg;
  assign gnt_id = gnt_id_reg;
  assign err_id = err_id_reg;

endmodule

// File: tb/tb_req_ack_arb.sv
// tb_req_ack_arb
// Directed bench for req_ack_arb: a 4-channel/latency-2 instance and a
// 3-channel/latency-1 instance share one clock. Inputs change 1ns after a
// rising edge, outputs are checked at that same point.
module tb_req_ack_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NUM_CH=4, ACK_LATENCY=2
  logic       rst4_n;
  logic [3:0] req4, ack4;
  logic       busy4, err4;
  logic [1:0] gnt4, eid4;

  // NUM_CH=3, ACK_LATENCY=1
  logic       rst3_n;
  logic [2:0] req3, ack3;
  logic       busy3, err3;
  logic [1:0] gnt3, eid3;

  req_ack_arb #(.NUM_CH(4), .ACK_LATENCY(2)) dut4 (
    .clk(clk), .rst_n(rst4_n), .req(req4), .ack(ack4),
    .busy(busy4), .gnt_id(gnt4), .err(err4), .err_id(eid4)
  );

  req_ack_arb #(.NUM_CH(3), .ACK_LATENCY(1)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req(req3), .ack(ack3),
    .busy(busy3), .gnt_id(gnt3), .err(err3), .err_id(eid3)
  );

  bind req_ack_arb req_ack_arb_sva #(.NUM_CH(NUM_CH), .ACK_LATENCY(ACK_LATENCY)) u_sva (
    .clk(clk), .rst_n(rst_n), .ack(ack), .busy(busy), .err(err), .state(state_reg)
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    if (obs === exp) $display("ok   %-16s value=%0h", tag, obs);
  endtask

  task automatic expect4(input string tag, input logic [3:0] a, input logic b,
                         input logic [1:0] g, input logic e, input logic [1:0] ei);
    chk({tag, ".ack"},    32'(ack4),  32'(a));
    chk({tag, ".busy"},   32'(busy4), 32'(b));
    chk({tag, ".gnt_id"}, 32'(gnt4),  32'(g));
    chk({tag, ".err"},    32'(err4),  32'(e));
    chk({tag, ".err_id"}, 32'(eid4),  32'(ei));
  endtask

  task automatic expect3(input string tag, input logic [2:0] a, input logic b,
                         input logic [1:0] g, input logic e);
    chk({tag, ".ack"},    32'(ack3),  32'(a));
    chk({tag, ".busy"},   32'(busy3), 32'(b));
    chk({tag, ".gnt_id"}, 32'(gnt3),  32'(g));
    chk({tag, ".err"},    32'(err3),  32'(e));
  endtask

  initial begin
    rst4_n = 1'b0;
    rst3_n = 1'b0;
    req4   = '0;
    req3   = '0;
    step();
    step();
    expect4("rst4", 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    expect3("rst3", 3'b000, 1'b0, 2'd0, 1'b0);
    rst4_n = 1'b1;
    rst3_n = 1'b1;

    // Single request on ch1, dropped when ack is seen
    req4 = 4'b0010;
    step(); expect4("s1.grant", 4'b0000, 1'b1, 2'd1, 1'b0, 2'd0);
    step(); expect4("s1.wait",  4'b0000, 1'b1, 2'd1, 1'b0, 2'd0);
    step(); expect4("s1.ack",   4'b0010, 1'b1, 2'd1, 1'b0, 2'd0);
    req4 = 4'b0000;
    step(); expect4("s1.done",  4'b0000, 1'b0, 2'd1, 1'b0, 2'd0);
    step(); expect4("s1.idle",  4'b0000, 1'b0, 2'd1, 1'b0, 2'd0);

    // Reset pointer to 0, then all four channels request together
    rst4_n = 1'b0;
    step(); expect4("s2.rst", 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    rst4_n = 1'b1;
    req4 = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step(); expect4($sformatf("s2.grant%0d", k), 4'b0000, 1'b1, 2'(k), 1'b0, 2'd0);
      step(); chk($sformatf("s2.wait%0d", k), 32'(ack4), 32'd0);
      step(); chk($sformatf("s2.ack%0d", k), 32'(ack4), 32'(4'b0001 << k));
      req4[k] = 1'b0;
      step(); expect4($sformatf("s2.done%0d", k), 4'b0000, 1'b0, 2'(k), 1'b0, 2'd0);
    end

    // ch2 held high for 12 cycles: an ack every 4 cycles
    req4 = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("s3.ack.c%0d", c), 32'(ack4), (c % 4 == 3) ? 32'h4 : 32'h0);
      chk($sformatf("s3.err.c%0d", c), 32'(err4), 32'd0);
    end
    req4 = 4'b0000;

    // Abort on ch3 (pointer now 3), ch0 pending behind it
    req4 = 4'b1001;
    step(); expect4("s4.grant",   4'b0000, 1'b1, 2'd3, 1'b0, 2'd0);
    req4 = 4'b0001;
    step(); expect4("s4.abort",   4'b0000, 1'b0, 2'd3, 1'b1, 2'd3);
    step(); expect4("s4.regrant", 4'b0000, 1'b1, 2'd0, 1'b0, 2'd3);
    step(); expect4("s4.wait",    4'b0000, 1'b1, 2'd0, 1'b0, 2'd3);
    step(); expect4("s4.ack",     4'b0001, 1'b1, 2'd0, 1'b0, 2'd3);
    req4 = 4'b0000;
    step(); expect4("s4.done",    4'b0000, 1'b0, 2'd0, 1'b0, 2'd3);

    // Reset while ch0 is in GRANT
    req4 = 4'b0001;
    step(); expect4("s5.grant",   4'b0000, 1'b1, 2'd0, 1'b0, 2'd3);
    rst4_n = 1'b0;
    step(); expect4("s5.rst",     4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    rst4_n = 1'b1;
    step(); expect4("s5.regrant", 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0);
    step(); expect4("s5.wait",    4'b0000, 1'b1, 2'd0, 1'b0, 2'd0);
    step(); expect4("s5.ack",     4'b0001, 1'b1, 2'd0, 1'b0, 2'd0);
    req4 = 4'b0000;
    step(); expect4("s5.done",    4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);

    // 3 channels, latency 1: ch0 keeps requesting so it is served again after the wrap
    req3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      int ch;
      ch = (k == 3) ? 0 : k;
      step(); expect3($sformatf("s6.grant%0d", k), 3'b000, 1'b1, 2'(ch), 1'b0);
      step(); expect3($sformatf("s6.ack%0d", k), 3'(3'b001 << ch), 1'b1, 2'(ch), 1'b0);
      if (ch != 0) req3[ch] = 1'b0;
      step(); expect3($sformatf("s6.done%0d", k), 3'b000, 1'b0, 2'(ch), 1'b0);
    end
    req3 = 3'b000;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
